// File: rtl/rr_grant_scheduler8_pkg.sv
// Shared types and helpers for the 8-way round-robin grant scheduler.
// The rotating priority search lives here so it can be reused by other arbiters.
package rr_grant_scheduler8_pkg;

  localparam int N_REQ = 8;
  localparam int IDX_W = 3;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } arb_state_e;

  // Width of a counter that must reach max_hold; never narrower than 1 bit.
  function automatic int hold_cnt_width(input int max_hold);
    return (max_hold < 1) ? 1 : $clog2(max_hold + 1);
  endfunction

  // Rotate so ptr lands at bit 0, find the lowest set bit, then add ptr back.
  // The 3-bit add wraps modulo 8 on its own. Returns ptr when req is all-zero.
  function automatic logic [IDX_W-1:0] rr_pick(input logic [N_REQ-1:0] req,
                                               input logic [IDX_W-1:0] ptr);
    logic [N_REQ-1:0] rot;
    logic [IDX_W-1:0] off;
    rot = N_REQ'({req, req} >> ptr);
    off = '0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      if (rot[i]) off = IDX_W'(i);
    end
    return ptr + off;
  endfunction

endpackage

// File: rtl/rr_grant_scheduler8_decoder3x8.sv
// 3-to-8 one-hot decoder with an enable; output is all-zero while disabled.
module rr_grant_scheduler8_decoder3x8 (
  input  logic [2:0] idx_i,
  input  logic       en_i,
  output logic [7:0] onehot_o
);

  always_comb begin
    onehot_o = '0;
    for (int i = 0; i < 8; i++) begin
      if (en_i && (idx_i == 3'(i))) onehot_o[i] = 1'b1;
    end
  end

endmodule

// File: rtl/rr_grant_scheduler8.sv
// Round-robin scheduler: one owner at a time among 8 requesters, with a
// hold timer that revokes grants kept longer than MAX_HOLD cycles.
module rr_grant_scheduler8
  import rr_grant_scheduler8_pkg::*;
#(
  parameter int MAX_HOLD = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_REQ-1:0] req,
  input  logic             done,
  output logic [N_REQ-1:0] gnt,
  output logic [IDX_W-1:0] gnt_idx,
  output logic             gnt_valid,
  output logic             timeout,
  output logic             dbg_state_o,
  output logic [IDX_W-1:0] dbg_ptr_o
);

  localparam int HC_W = hold_cnt_width(MAX_HOLD);
  localparam bit TIMER_EN = (MAX_HOLD != 0);
  localparam logic [HC_W-1:0] HOLD_LAST = TIMER_EN ? HC_W'(MAX_HOLD - 1) : '0;
  localparam logic [HC_W-1:0] HOLD_SAT  = HC_W'(MAX_HOLD);

  // Handshake: req[i] is a level held until served; once granted, the owner
  // keeps gnt until it pulses done, drops req[i], or the hold timer expires.
  // A released grant is always followed by exactly one cycle with gnt=0.

  arb_state_e       state_q, state_d;
  logic [IDX_W-1:0] ptr_q, ptr_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [HC_W-1:0]  hold_q, hold_d;
  logic             timeout_q, timeout_d;

  logic             rel_done;
  logic             rel_drop;
  logic             rel_timer;
  logic [IDX_W-1:0] winner;

  assign winner    = rr_pick(req, ptr_q);
  assign rel_done  = done;
  assign rel_drop  = ~req[idx_q];
  assign rel_timer = TIMER_EN && (hold_q == HOLD_LAST);

  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    idx_d     = idx_q;
    hold_d    = hold_q;
    timeout_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (|req) begin
          state_d = GRANT;
          idx_d   = winner;
          hold_d  = '0;
        end
      end
      GRANT: begin
        if (rel_done || rel_drop || rel_timer) begin
          state_d   = IDLE;
          ptr_d     = idx_q + IDX_W'(1);
          timeout_d = rel_timer && !rel_done && !rel_drop;
        end else if (hold_q != HOLD_SAT) begin
          hold_d = hold_q + HC_W'(1);
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      ptr_q     <= '0;
      idx_q     <= '0;
      hold_q    <= '0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      idx_q     <= idx_d;
      hold_q    <= hold_d;
      timeout_q <= timeout_d;
    end
  end

  assign gnt_idx     = idx_q;
  assign gnt_valid   = (state_q == GRANT);
  assign timeout     = timeout_q;
  assign dbg_state_o = state_q;
  assign dbg_ptr_o   = ptr_q;

  rr_grant_scheduler8_decoder3x8 u_dec (
    .idx_i    (idx_q),
    .en_i     (gnt_valid),
    .onehot_o (gnt)
  );

endmodule

// File: tb/tb_rr_grant_scheduler8.sv
// Bench for rr_grant_scheduler8: directed scenarios plus random traffic,
// all outputs checked every cycle against a behavioural arbiter model.
module tb_rr_grant_scheduler8;

  localparam int MH = 4;
  localparam int W  = 16;

  logic       clk;
  logic       rst_n;
  logic [7:0] req;
  logic       done;
  logic [7:0] gnt;
  logic [2:0] gnt_idx;
  logic       gnt_valid;
  logic       timeout;
  logic       dbg_state;
  logic [2:0] dbg_ptr;

  int n_tests = 0;
  int n_fail  = 0;

  logic [W-1:0] exp_q[$];

  rr_grant_scheduler8 #(.MAX_HOLD(MH)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req         (req),
    .done        (done),
    .gnt         (gnt),
    .gnt_idx     (gnt_idx),
    .gnt_valid   (gnt_valid),
    .timeout     (timeout),
    .dbg_state_o (dbg_state),
    .dbg_ptr_o   (dbg_ptr)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input logic [15:0] got, input logic [15:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  // Reference model: tracks owner, cycles held so far and the next-search start.
  bit m_busy = 0;
  int m_idx  = 0;
  int m_ptr  = 0;
  int m_held = 0;
  bit m_to   = 0;

  always @(posedge clk) begin
    bit rel_t;
    bit rel_d;
    bit rel_r;
    logic [7:0] g;
    if (!rst_n) begin
      m_busy = 0; m_idx = 0; m_ptr = 0; m_held = 0; m_to = 0;
    end else if (!m_busy) begin
      m_to = 0;
      if (req != 8'h00) begin
        for (int k = 0; k < 8; k++) begin
          if (req[(m_ptr + k) % 8]) begin
            m_idx = (m_ptr + k) % 8;
            break;
          end
        end
        m_busy = 1;
        m_held = 0;
      end
    end else begin
      m_held = m_held + 1;
      rel_d = (done === 1'b1);
      rel_r = (req[m_idx] === 1'b0);
      rel_t = (MH != 0) && (m_held == MH);
      m_to = rel_t && !rel_d && !rel_r;
      if (rel_d || rel_r || rel_t) begin
        m_busy = 0;
        m_ptr  = (m_idx + 1) % 8;
      end
    end
    g = m_busy ? (8'h01 << m_idx) : 8'h00;
    exp_q.push_back({3'(m_ptr), m_to, m_busy, 3'(m_idx), g});
  end

  // monitor: every cycle the DUT presents registered outputs
  always @(negedge clk) begin
    logic [W-1:0] e;
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      check("gnt",       16'(gnt),       16'(e[7:0]));
      check("gnt_idx",   16'(gnt_idx),   16'(e[10:8]));
      check("gnt_valid", 16'(gnt_valid), 16'(e[11]));
      check("state",     16'(dbg_state), 16'(e[11]));
      check("timeout",   16'(timeout),   16'(e[12]));
      check("ptr",       16'(dbg_ptr),   16'(e[15:13]));
      check("onehot",    16'($countones(gnt) <= 1), 16'd1);
    end
  end

  // driver tasks
  task automatic wait_grant(input int exp_idx);
    int k;
    for (k = 0; k < 40; k++) begin
      @(negedge clk);
      if (gnt_valid === 1'b1) break;
    end
    check("grant_wait", 16'(k < 40), 16'd1);
    check("grant_order", 16'(gnt_idx), 16'(exp_idx));
  endtask

  task automatic pulse_done();
    done = 1'b1;
    @(negedge clk);
    done = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    req   = 8'h00;
    done  = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    int cnt;
    // T1 reset with all requests up
    rst_n = 1'b0;
    req   = 8'hFF;
    done  = 1'b0;
    repeat (3) @(negedge clk);
    check("t1_gnt", 16'(gnt), 16'h0);
    check("t1_valid", 16'(gnt_valid), 16'h0);

    // T2 single request released by done
    rst_n = 1'b1;
    req   = 8'h04;
    wait_grant(2);
    check("t2_gnt", 16'(gnt), 16'h04);
    pulse_done();
    req = 8'h00;
    check("t2_gnt_off", 16'(gnt), 16'h0);
    check("t2_ptr", 16'(dbg_ptr), 16'd3);

    // T3 fairness across all eight
    do_reset();
    req = 8'hFF;
    for (int i = 0; i < 9; i++) begin
      wait_grant(i % 8);
      pulse_done();
      check("t3_idle", 16'(gnt), 16'h0);
    end
    req = 8'h00;

    // T4 wrap from 6 to 7 to 0, then drop req mid-grant
    do_reset();
    req = 8'h40;
    wait_grant(6);
    req = 8'h81;
    pulse_done();
    wait_grant(7);
    pulse_done();
    wait_grant(0);
    req = 8'h00;
    @(negedge clk);
    check("t4_drop_gnt", 16'(gnt), 16'h0);
    check("t4_drop_to", 16'(timeout), 16'h0);

    // T5 hold timeout, then done in the final cycle
    do_reset();
    req = 8'h03;
    wait_grant(0);
    cnt = 1;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (gnt_valid !== 1'b1) break;
      cnt++;
    end
    check("t5_hold_len", 16'(cnt), 16'(MH));
    check("t5_timeout", 16'(timeout), 16'h1);
    wait_grant(1);
    check("t5_gnt1", 16'(gnt), 16'h02);
    repeat (MH - 1) @(negedge clk);
    check("t5_last_cycle", 16'(gnt_valid), 16'h1);
    pulse_done();
    check("t5_done_to", 16'(timeout), 16'h0);
    check("t5_done_gnt", 16'(gnt), 16'h0);
    req = 8'h00;

    // T6 reset mid-grant clears ptr
    do_reset();
    req = 8'h10;
    wait_grant(4);
    rst_n = 1'b0;
    @(negedge clk);
    check("t6_gnt", 16'(gnt), 16'h0);
    req   = 8'hFF;
    rst_n = 1'b1;
    wait_grant(0);
    pulse_done();
    req = 8'h00;

    // random traffic, including done in IDLE and occasional resets
    do_reset();
    repeat (800) begin
      @(negedge clk);
      if ($urandom_range(0, 99) < 25) req = 8'($urandom_range(0, 255));
      done  = ($urandom_range(0, 3) == 0);
      rst_n = ($urandom_range(0, 99) != 0);
    end
    rst_n = 1'b1;
    req   = 8'h00;
    done  = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
